conv_serial_engine: RTL and testbench

- Parametrised single-MAC convolution engine: valid (no padding, stride 1) 2-D convolution of an IMG_N x IMG_N unsigned image with a K x K unsigned kernel.
- One processing element is time-multiplexed over every output pixel, with a start/busy/done handshake.
- Results are emitted as a per-pixel stream and also held on a flattened output bus.
- Generalises the fixed 4x4 / 3x3 / 8-bit systolic convolution blocks, and adds operand capture, abort and result indexing.

---
 rtl/conv_serial_engine_if.sv | 31 +++
 rtl/conv_serial_engine.sv | 144 ++++++++++++++
 tb/tb_conv_serial_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_serial_engine_if.sv
// Operand, handshake and result bus of conv_serial_engine; parameters must match the engine instance.
interface conv_serial_engine_if #(
  parameter int DW    = 8,
  parameter int IMG_N = 4,
  parameter int K     = 3
);
  localparam int OUT_N = IMG_N - K + 1;
  localparam int P     = OUT_N * OUT_N;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;

  logic                      start;
  logic                      abort;
  logic [IMG_N*IMG_N*DW-1:0] img_flat;
  logic [K*K*DW-1:0]         ker_flat;
  logic                      busy;
  logic                      done;
  logic                      res_valid;
  logic [DW-1:0]             res_data;
  logic [IDX_W-1:0]          res_idx;
  logic [P*DW-1:0]           out_flat;

  modport master (
    output start, abort, img_flat, ker_flat,
    input  busy, done, res_valid, res_data, res_idx, out_flat
  );

  modport slave (
    input  start, abort, img_flat, ker_flat,
    output busy, done, res_valid, res_data, res_idx, out_flat
  );
endinterface

// File: rtl/conv_serial_engine.sv
// Single-MAC valid 2-D convolution, one tap per cycle, start/busy/done; CONV_SAT_EN selects saturating output.
// Latency P*(K*K+1) cycles from start to done; no backpressure, start ignored unless IDLE, abort wins over start.
module conv_serial_engine #(
  parameter int DW    = 8,
  parameter int IMG_N = 4,
  parameter int K     = 3,
  parameter int ACC_W = 20
) (
  input logic               clk_in,
  input logic               rst,
  conv_serial_engine_if.slave bus
);
  localparam int OUT_N = IMG_N - K + 1;
  localparam int P     = OUT_N * OUT_N;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int OW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  state_t                    state;
  logic [IMG_N*IMG_N*DW-1:0] img_q;
  logic [K*K*DW-1:0]         ker_q;
  logic [ACC_W-1:0]          acc;
  logic [OW-1:0]             row, col;
  logic [KW-1:0]             kr, kc;
  logic [IDX_W-1:0]          idx;
  logic                      busy_q, done_q, vld_q;
  logic [DW-1:0]             data_q;
  logic [IDX_W-1:0]          ridx_q;
  logic [P*DW-1:0]           out_q;

  int                        pix_sh, ker_sh;
  logic [DW-1:0]             pix, kw, red;
  logic [ACC_W-1:0]          prod, acc_nxt;
  logic                      first_tap, last_tap;
  logic [P*DW-1:0]           out_nxt;

  always_comb begin
    pix_sh    = ((int'(row) + int'(kr)) * IMG_N + int'(col) + int'(kc)) * DW;
    ker_sh    = (int'(kr) * K + int'(kc)) * DW;
    pix       = DW'(img_q >> pix_sh);
    kw        = DW'(ker_q >> ker_sh);
    prod      = ACC_W'(pix) * ACC_W'(kw);
    first_tap = (kr == '0) && (kc == '0);
    last_tap  = (kr == KW'(K - 1)) && (kc == KW'(K - 1));
    acc_nxt   = first_tap ? prod : acc + prod;
  end

`ifdef CONV_SAT_EN
  assign red = (|acc_nxt[ACC_W-1:DW]) ? {DW{1'b1}} : acc_nxt[DW-1:0];
`else
  assign red = acc_nxt[DW-1:0];
`endif

  // Result lands in its out_flat slot on the same edge that raises res_valid.
  always_comb begin
    out_nxt = out_q;
    for (int p = 0; p < P; p++) begin
      if (idx == IDX_W'(p)) out_nxt[p*DW +: DW] = red;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      img_q  <= '0;
      ker_q  <= '0;
      acc    <= '0;
      row    <= '0;
      col    <= '0;
      kr     <= '0;
      kc     <= '0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
      ridx_q <= '0;
      out_q  <= '0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            img_q  <= bus.img_flat;
            ker_q  <= bus.ker_flat;
            row    <= '0;
            col    <= '0;
            kr     <= '0;
            kc     <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
          RUN: begin
            acc <= acc_nxt;
            if (last_tap) begin
              kr     <= '0;
              kc     <= '0;
              vld_q  <= 1'b1;
              data_q <= red;
              ridx_q <= idx;
              out_q  <= out_nxt;
              state  <= WRITE;
            end else if (kc == KW'(K - 1)) begin
              kc <= '0;
              kr <= kr + KW'(1);
            end else begin
              kc <= kc + KW'(1);
            end
          end
          WRITE: if (idx == IDX_W'(P - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
            if (col == OW'(OUT_N - 1)) begin
              col <= '0;
              row <= row + OW'(1);
            end else begin
              col <= col + OW'(1);
            end
            state <= RUN;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_valid = vld_q;
  assign bus.res_data  = data_q;
  assign bus.res_idx   = ridx_q;
  assign bus.out_flat  = out_q;
endmodule

// File: tb/tb_conv_serial_engine.sv
// Directed bench for conv_serial_engine: 4x4/3x3 and 5x5/2x2 instances with a cycle-stamped result scoreboard.
module tb_conv_serial_engine;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_serial_engine_if #(.DW(8), .IMG_N(4), .K(3)) bus_a ();
  conv_serial_engine_if #(.DW(8), .IMG_N(5), .K(2)) bus_b ();

  conv_serial_engine #(.DW(8), .IMG_N(4), .K(3), .ACC_W(20)) dut_a (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus_a.slave)
  );

  conv_serial_engine #(.DW(8), .IMG_N(5), .K(2), .ACC_W(20)) dut_b (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus_b.slave)
  );

  typedef struct {
    int cyc;
    int idx;
    int data;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];
  int   im[25];
  int   kr[9];
  int   exp_a[4];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic fill(input int ival, input int kval);
    for (int i = 0; i < 25; i++) im[i] = ival;
    for (int i = 0; i < 9; i++) kr[i] = kval;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 25; i++) im[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++) kr[i] = int'($urandom_range(0, 255));
  endtask

  task automatic apply(input int sel);
    if (sel == 0) begin
      for (int i = 0; i < 16; i++) bus_a.img_flat[i*8 +: 8] = 8'(im[i]);
      for (int i = 0; i < 9; i++) bus_a.ker_flat[i*8 +: 8] = 8'(kr[i]);
    end else begin
      for (int i = 0; i < 25; i++) bus_b.img_flat[i*8 +: 8] = 8'(im[i]);
      for (int i = 0; i < 4; i++) bus_b.ker_flat[i*8 +: 8] = 8'(kr[i]);
    end
  endtask

  // Reference convolution; only events at or before cycle 'cut' are expected.
  task automatic push_job(input int sel, input int base, input int cut);
    int n, k, on, acc, d, c;
    exp_t e;
    n  = (sel != 0) ? 5 : 4;
    k  = (sel != 0) ? 2 : 3;
    on = n - k + 1;
    for (int r = 0; r < on; r++) begin
      for (int q = 0; q < on; q++) begin
        acc = 0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            acc += (im[(r+i)*n + q + j] & 255) * (kr[i*k + j] & 255);
`ifdef CONV_SAT_EN
        d = (acc > 255) ? 255 : acc;
`else
        d = acc % 256;
`endif
        c = base + (r*on + q + 1) * (k*k + 1);
        if (c <= cut) begin
          e.cyc  = c;
          e.idx  = r*on + q;
          e.data = d;
          sb.push_back(e);
          if (sel == 0) exp_a[r*on + q] = d;
        end
      end
    end
    c = base + on*on*(k*k + 1) + 1;
    if (c <= cut) done_q.push_back(c);
  endtask

  task automatic kick(input int sel);
    if (sel == 0) bus_a.start = 1'b1;
    else          bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // Steps cycles 1..ncyc of a job; start re-pulses at s1/s2/s3, abort at ab (0 = none).
  task automatic run(input int sel, input int ncyc, input int ab, input int s1, input int s2, input int s3);
    logic       vld, dn, bsy, st, abt;
    logic [7:0] rd;
    logic [3:0] ri;
    exp_t       e;
    int         dc;
    for (int c = 1; c <= ncyc; c++) begin
      st  = (c == s1) || (c == s2) || (c == s3);
      abt = (c == ab);
      if (sel == 0) begin
        bus_a.start = st;
        bus_a.abort = abt;
        vld = bus_a.res_valid;
        dn  = bus_a.done;
        bsy = bus_a.busy;
        rd  = bus_a.res_data;
        ri  = 4'(bus_a.res_idx);
      end else begin
        bus_b.start = st;
        bus_b.abort = abt;
        vld = bus_b.res_valid;
        dn  = bus_b.done;
        bsy = bus_b.busy;
        rd  = bus_b.res_data;
        ri  = bus_b.res_idx;
      end
      if (c == 1 && ab != 1) check("busy_in_run", bsy, 1'b1);
      if (vld !== 1'b0) begin
        if (sb.size() == 0) check("res_valid_spurious", vld, 1'b0);
        else begin
          e = sb.pop_front();
          check("res_cycle", c, e.cyc);
          check("res_idx", ri, e.idx);
          check("res_data", rd, e.data);
        end
      end
      if (dn !== 1'b0) begin
        if (done_q.size() == 0) check("done_spurious", dn, 1'b0);
        else begin
          dc = done_q.pop_front();
          check("done_cycle", c, dc);
          check("busy_in_done", bsy, 1'b0);
        end
      end
      if (ab != 0 && c == ab + 1) check("busy_after_abort", bsy, 1'b0);
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    check("results_missing", sb.size(), 0);
    check("done_missing", done_q.size(), 0);
  endtask

  task automatic check_out_a(input string tag);
    logic [31:0] e;
    for (int p = 0; p < 4; p++) e[p*8 +: 8] = 8'(exp_a[p]);
    check(tag, bus_a.out_flat, e);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"}, bus_a.busy, 1'b0);
    check({tag, "_done"}, bus_a.done, 1'b0);
    check({tag, "_valid"}, bus_a.res_valid, 1'b0);
    check({tag, "_data"}, bus_a.res_data, 8'd0);
    check({tag, "_idx"}, bus_a.res_idx, 2'd0);
    check({tag, "_out"}, bus_a.out_flat, 32'd0);
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.img_flat = '0; bus_a.ker_flat = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.img_flat = '0; bus_b.ker_flat = '0;
    for (int p = 0; p < 4; p++) exp_a[p] = 0;
    #2 rst = 1'b0;
    #10;
    check_zero_a("reset");
    check("reset_b_busy", bus_b.busy, 1'b0);
    check("reset_b_out", bus_b.out_flat, 128'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // All ones: 9 per pixel, done in cycle 41
    fill(1, 1); apply(0); push_job(0, 0, BIG);
    kick(0); run(0, 41, 0, 0, 0, 0);
    check_out_a("out_ones");
    check("res_data_hold", bus_a.res_data, 8'd9);
    check("res_idx_hold", bus_a.res_idx, 2'd3);

    // Centre-tap kernel over a 16r+c image
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) im[r*4 + c] = 16*r + c;
    for (int i = 0; i < 9; i++) kr[i] = (i == 4) ? 1 : 0;
    apply(0); push_job(0, 0, BIG);
    kick(0); run(0, 41, 0, 0, 0, 0);
    check_out_a("out_centre");

    // Full-scale operands
    fill(255, 255); apply(0); push_job(0, 0, BIG);
    kick(0); run(0, 41, 0, 0, 0, 0);
    check_out_a("out_full");

    // Operands change after capture; start at 5 and 41 ignored, at 42 accepted
    randomize_ops(); apply(0); push_job(0, 0, BIG);
    kick(0);
    randomize_ops(); apply(0); push_job(0, 42, BIG);
    run(0, 83, 0, 5, 41, 42);
    check_out_a("out_restart");

    // Abort in cycle 25: slots 0-1 rewritten, 2-3 retained, no done
    fill(2, 1); apply(0); push_job(0, 0, 25);
    kick(0); run(0, 30, 25, 0, 0, 0);
    check_out_a("out_abort");
    randomize_ops(); apply(0); push_job(0, 0, BIG);
    kick(0); run(0, 41, 0, 0, 0, 0);
    check_out_a("out_after_abort");

    // Reset during cycle 15 clears everything at once
    fill(1, 1); apply(0); push_job(0, 0, 14);
    kick(0); run(0, 14, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_zero_a("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 5x5 image, 2x2 kernel: 16 results of 4, done in cycle 81
    fill(1, 1); apply(1); push_job(1, 0, BIG);
    kick(1); run(1, 81, 0, 0, 0, 0);
    check("a_idle_after_reset", bus_a.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
